vga_timing_gen: RTL and testbench

//   Parametrised VGA raster timing generator: 2-D horizontal/vertical counters with sync, blanking and pixel coordinates.

---
 rtl/vga_timing_gen.sv | 117 +++++++++++
 tb/tb_vga_timing_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. A horizontal pixel counter and a
//   vertical line counter advance on each clk edge where the pixel tick `en`
//   is high. From them the block derives sync pulses, the visible-area flag
//   and the pixel coordinates for the downstream colour generator.
//
// Ports
//   clk        in   1      system clock
//   rst_n      in   1      asynchronous reset, active-low
//   en         in   1      pixel tick; state advances only on edges with en=1
//   hcnt       out  CNT_W  horizontal position, 0..H_TOTAL-1
//   vcnt       out  CNT_W  vertical position, 0..V_TOTAL-1
//   hsync      out  1      horizontal sync, active level HS_POL
//   vsync      out  1      vertical sync, active level VS_POL
//   video_on   out  1      high inside the visible area
//   x          out  CNT_W  pixel column inside the visible area, else 0
//   y          out  CNT_W  pixel row inside the visible area, else 0
//   line_end   out  1      en=1 while on the last pixel of a line
//   frame_end  out  1      line_end on the last line of the frame
//
// Handshake: there is no ready path. `en` is a strobe: every clk edge with
//   en=1 consumes exactly one pixel slot, and an edge with en=0 changes
//   nothing. line_end/frame_end are combinational and qualified by en, so
//   consumers must sample them on clk.
//
// CNT_W must be wide enough for 2**CNT_W >= max(H_TOTAL, V_TOTAL).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_end,
  output logic             frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             h_last;
  logic             v_last;
  logic             vis_next;
  logic             hs_next;
  logic             vs_next;

  assign h_last = (hcnt == H_LAST);
  assign v_last = (vcnt == V_LAST);

  // Next raster position if this edge carries a pixel tick.
  always_comb begin
    h_next = hcnt + CNT_W'(1);
    v_next = vcnt;
    if (h_last) begin
      h_next = '0;
      v_next = v_last ? '0 : vcnt + CNT_W'(1);
    end
  end

  // Decoding the next counts (not the current ones) lets the registered
  // sync/visibility outputs line up with the counter value of the same cycle.
  assign vis_next = (h_next < H_VIS) && (v_next < V_VIS);
  assign hs_next  = (h_next >= HS_START) && (h_next < HS_END);
  assign vs_next  = (v_next >= VS_START) && (v_next < VS_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt     <= '0;
      vcnt     <= '0;
      hsync    <= ~HS_POL;
      vsync    <= ~VS_POL;
      video_on <= 1'b0;
      x        <= '0;
      y        <= '0;
    end else if (en) begin
      hcnt     <= h_next;
      vcnt     <= v_next;
      hsync    <= hs_next ? HS_POL : ~HS_POL;
      vsync    <= vs_next ? VS_POL : ~VS_POL;
      video_on <= vis_next;
      x        <= vis_next ? h_next : '0;
      y        <= vis_next ? v_next : '0;
    end
  end

  // Gated by en so a stalled pixel clock never stretches the pulse.
  assign line_end  = en && h_last;
  assign frame_end = line_end && v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en_a, en_b, en_c;

  // Instance A: default 640x480 mode
  logic [9:0] a_hcnt, a_vcnt, a_x, a_y;
  logic       a_hsync, a_vsync, a_video_on, a_line_end, a_frame_end;

  // Instance B: tiny mode (H 8/2/3/2 = 15, V 6/1/2/1 = 10) for whole-frame checks
  logic [3:0] b_hcnt, b_vcnt, b_x, b_y;
  logic       b_hsync, b_vsync, b_video_on, b_line_end, b_frame_end;

  // Instance C: 800-wide mode, H_TOTAL 1056, active-high hsync
  logic [10:0] c_hcnt, c_vcnt, c_x, c_y;
  logic        c_hsync, c_vsync, c_video_on, c_line_end, c_frame_end;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a),
    .hcnt(a_hcnt), .vcnt(a_vcnt), .hsync(a_hsync), .vsync(a_vsync),
    .video_on(a_video_on), .x(a_x), .y(a_y),
    .line_end(a_line_end), .frame_end(a_frame_end)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b),
    .hcnt(b_hcnt), .vcnt(b_vcnt), .hsync(b_hsync), .vsync(b_vsync),
    .video_on(b_video_on), .x(b_x), .y(b_y),
    .line_end(b_line_end), .frame_end(b_frame_end)
  );

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .HS_POL(1'b1), .CNT_W(11)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_c),
    .hcnt(c_hcnt), .vcnt(c_vcnt), .hsync(c_hsync), .vsync(c_vsync),
    .video_on(c_video_on), .x(c_x), .y(c_y),
    .line_end(c_line_end), .frame_end(c_frame_end)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int hs_cnt, vs_cnt, vis_cnt, le_cnt, fe_cnt, fe_alone;

  initial begin
    rst_n = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    en_c  = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_hcnt",     32'(a_hcnt), 0);
    check("rst_vcnt",     32'(a_vcnt), 0);
    check("rst_hsync",    32'(a_hsync), 1);
    check("rst_vsync",    32'(a_vsync), 1);
    check("rst_video_on", 32'(a_video_on), 0);
    check("rst_x",        32'(a_x), 0);
    check("rst_y",        32'(a_y), 0);
    check("rst_line_end", 32'(a_line_end), 0);
    check("rst_frame_end",32'(a_frame_end), 0);
    check("rst_c_hsync",  32'(c_hsync), 0);

    // Run to hcnt=300, then assert reset between edges
    rst_n = 1'b1;
    en_a  = 1'b1;
    repeat (300) tick();
    check("mid_hcnt",     32'(a_hcnt), 300);
    check("mid_vcnt",     32'(a_vcnt), 0);
    check("mid_video_on", 32'(a_video_on), 1);
    check("mid_x",        32'(a_x), 300);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_hcnt",     32'(a_hcnt), 0);
    check("async_video_on", 32'(a_video_on), 0);
    check("async_x",        32'(a_x), 0);
    check("async_hsync",    32'(a_hsync), 1);
    check("async_vsync",    32'(a_vsync), 1);
    tick();
    rst_n = 1'b1;

    // One full default line: sample state hcnt=i before each edge
    hs_cnt = 0;
    le_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (a_hsync == 1'b0) hs_cnt++;
      if (a_line_end) le_cnt++;
      case (i)
        1:   check("first_edge_hcnt", 32'(a_hcnt), 1);
        639: begin
          check("h639_video_on", 32'(a_video_on), 1);
          check("h639_x",        32'(a_x), 639);
        end
        640: begin
          check("h640_video_on", 32'(a_video_on), 0);
          check("h640_x",        32'(a_x), 0);
        end
        655: check("h655_hsync", 32'(a_hsync), 1);
        656: check("h656_hsync", 32'(a_hsync), 0);
        751: check("h751_hsync", 32'(a_hsync), 0);
        752: check("h752_hsync", 32'(a_hsync), 1);
        799: begin
          check("h799_hcnt",      32'(a_hcnt), 799);
          check("h799_line_end",  32'(a_line_end), 1);
          check("h799_frame_end", 32'(a_frame_end), 0);
        end
        default: ;
      endcase
      if (i < 799) tick();
    end
    check("a_hsync_low_cycles", 32'(hs_cnt), 96);
    check("a_line_end_count",   32'(le_cnt), 1);

    // en gating at hcnt=799: en 1 (above), 0, 0, 1
    en_a = 1'b0;
    #1;
    check("gate0_line_end", 32'(a_line_end), 0);
    tick();
    check("gate1_hcnt",     32'(a_hcnt), 799);
    check("gate1_line_end", 32'(a_line_end), 0);
    tick();
    check("gate2_hcnt",     32'(a_hcnt), 799);
    check("gate2_vcnt",     32'(a_vcnt), 0);
    en_a = 1'b1;
    #1;
    check("gate3_line_end", 32'(a_line_end), 1);
    tick();
    check("wrap_line_hcnt",     32'(a_hcnt), 0);
    check("wrap_line_vcnt",     32'(a_vcnt), 1);
    check("wrap_line_video_on", 32'(a_video_on), 1);
    check("wrap_line_y",        32'(a_y), 1);
    en_a = 1'b0;

    // Tiny mode: one frame to reach the wrap, then tally a whole frame
    reset_pulse();
    en_b = 1'b1;
    repeat (150) tick();
    check("b_wrap_hcnt",     32'(b_hcnt), 0);
    check("b_wrap_vcnt",     32'(b_vcnt), 0);
    check("b_wrap_video_on", 32'(b_video_on), 1);
    hs_cnt = 0; vs_cnt = 0; vis_cnt = 0; le_cnt = 0; fe_cnt = 0; fe_alone = 0;
    for (int i = 0; i < 150; i++) begin
      if (b_video_on) vis_cnt++;
      if (b_hsync == 1'b0) hs_cnt++;
      if (b_vsync == 1'b0) vs_cnt++;
      if (b_line_end) le_cnt++;
      if (b_frame_end) fe_cnt++;
      if (b_frame_end && !b_line_end) fe_alone++;
      if (i == 50) begin
        check("b_h5v3_hcnt", 32'(b_hcnt), 5);
        check("b_h5v3_vcnt", 32'(b_vcnt), 3);
        check("b_h5v3_x",    32'(b_x), 5);
        check("b_h5v3_y",    32'(b_y), 3);
      end
      if (i == 90) begin
        check("b_v6_video_on", 32'(b_video_on), 0);
        check("b_v6_y",        32'(b_y), 0);
      end
      if (i == 149) check("b_last_frame_end", 32'(b_frame_end), 1);
      tick();
    end
    check("b_video_on_cycles", 32'(vis_cnt), 48);
    check("b_hsync_low",       32'(hs_cnt), 30);
    check("b_vsync_low",       32'(vs_cnt), 30);
    check("b_line_end_count",  32'(le_cnt), 10);
    check("b_frame_end_count", 32'(fe_cnt), 1);
    check("b_frame_end_alone", 32'(fe_alone), 0);
    check("b_end_hcnt",        32'(b_hcnt), 0);
    check("b_end_vcnt",        32'(b_vcnt), 0);
    en_b = 1'b0;

    // Overridden horizontal timing with active-high hsync
    reset_pulse();
    en_c = 1'b1;
    hs_cnt = 0;
    for (int i = 0; i < 1056; i++) begin
      if (c_hsync == 1'b1) hs_cnt++;
      case (i)
        799:  check("c_h799_video_on", 32'(c_video_on), 1);
        800:  check("c_h800_video_on", 32'(c_video_on), 0);
        839:  check("c_h839_hsync", 32'(c_hsync), 0);
        840:  check("c_h840_hsync", 32'(c_hsync), 1);
        967:  check("c_h967_hsync", 32'(c_hsync), 1);
        968:  check("c_h968_hsync", 32'(c_hsync), 0);
        1055: begin
          check("c_h1055_hcnt",     32'(c_hcnt), 1055);
          check("c_h1055_line_end", 32'(c_line_end), 1);
        end
        default: ;
      endcase
      tick();
    end
    check("c_hsync_high_cycles", 32'(hs_cnt), 128);
    check("c_wrap_hcnt",         32'(c_hcnt), 0);
    check("c_wrap_vcnt",         32'(c_vcnt), 1);
    en_c = 1'b0;

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
